// File: rtl/operator_ip_pkg.sv
// Shared types and widths for the OPERATOR_IP host sequencer.
package operator_ip_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int RES_W  = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CFG_WR  = 3'd1,
    CFG_GAP = 3'd2,
    OP_WAIT = 3'd3,
    RESP    = 3'd4
  } op_host_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } op_cfg_wr_t;
endpackage

// File: rtl/op_sync_fifo.sv
// Single-clock FIFO with occupancy level; push and pop may happen in the same cycle.
module op_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
endmodule

// File: rtl/operator_ip_host.sv
// Host sequencer for OPERATOR_IP: drains queued register writes as spaced
// reg_wr strobes, then runs operand jobs and returns z on a valid/ready channel.
module operator_ip_host
  import operator_ip_pkg::*;
#(
  parameter int CFG_DEPTH  = 4,
  parameter int OP_LATENCY = 2,
  parameter int WR_GAP     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [ADDR_W-1:0]         cfg_addr,
  input  logic [DATA_W-1:0]         cfg_data,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [DATA_W-1:0]         job_a,
  input  logic [DATA_W-1:0]         job_b,
  input  logic [DATA_W-1:0]         job_c,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [RES_W-1:0]          res_z,
  output logic [ADDR_W-1:0]         reg_addr,
  output logic [DATA_W-1:0]         reg_wr_data,
  output logic                      reg_wr,
  output logic [DATA_W-1:0]         a,
  output logic [DATA_W-1:0]         b,
  output logic [DATA_W-1:0]         c,
  input  logic [RES_W-1:0]          z,
  output logic                      busy,
  output logic [$clog2(CFG_DEPTH):0] cfg_level
);
  localparam int LW    = $clog2(CFG_DEPTH) + 1;
  localparam int CNT_W = (OP_LATENCY > 1) ? $clog2(OP_LATENCY) : 1;
  localparam int GAP_W = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
  localparam logic [CNT_W-1:0] OP_LAST  = CNT_W'(OP_LATENCY - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((WR_GAP > 0) ? WR_GAP - 1 : 0);

  op_host_state_e   state, state_n;
  op_cfg_wr_t       cfg_in, head, last_cfg;
  logic             fifo_full, fifo_empty, pop, idle_ok, job_acc;
  logic [CNT_W-1:0] op_cnt;
  logic [GAP_W-1:0] gap_cnt;

  assign cfg_in = '{addr: cfg_addr, data: cfg_data};

  op_sync_fifo #(.WIDTH($bits(op_cfg_wr_t)), .DEPTH(CFG_DEPTH)) u_cfg_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cfg_valid && cfg_ready),
    .wdata (cfg_in),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (cfg_level)
  );

  assign cfg_ready = !fifo_full && !rst;
  assign job_ready = idle_ok && !rst;
  assign job_acc   = job_valid && job_ready;
  assign busy      = (state != IDLE) || !fifo_empty;

  // Writes leave the FIFO head directly on the strobe cycle, then hold.
  assign reg_addr    = (state == CFG_WR) ? head.addr : last_cfg.addr;
  assign reg_wr_data = (state == CFG_WR) ? head.data : last_cfg.data;

  always_comb begin
    state_n = state;
    idle_ok = 1'b0;
    pop     = 1'b0;
    reg_wr  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) state_n = CFG_WR;
        else begin
          idle_ok = 1'b1;
          if (job_valid) state_n = OP_WAIT;
        end
      end
      CFG_WR: begin
        reg_wr = 1'b1;
        pop    = 1'b1;
        // Leaving a write or gap re-runs the IDLE decision in the same cycle.
        if (WR_GAP > 0)             state_n = CFG_GAP;
        else if (cfg_level > LW'(1)) state_n = CFG_WR;
        else                         state_n = IDLE;
      end
      CFG_GAP: if (gap_cnt == GAP_LAST) state_n = fifo_empty ? IDLE : CFG_WR;
      OP_WAIT: if (op_cnt == OP_LAST)   state_n = RESP;
      RESP:    if (res_ready)           state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      op_cnt    <= '0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      res_z     <= '0;
      res_valid <= 1'b0;
      last_cfg  <= '0;
    end else begin
      state   <= state_n;
      gap_cnt <= (state == CFG_GAP) ? gap_cnt + 1'b1 : '0;
      op_cnt  <= (state == OP_WAIT) ? op_cnt + 1'b1 : '0;
      if (job_acc) begin
        a <= job_a;
        b <= job_b;
        c <= job_c;
      end
      if (state == OP_WAIT && op_cnt == OP_LAST) begin
        res_z     <= z;
        res_valid <= 1'b1;
      end else if (state == RESP && res_ready) begin
        res_valid <= 1'b0;
      end
      if (state == CFG_WR) last_cfg <= head;
    end
  end
endmodule

// File: tb/tb_operator_ip_host.sv
// Directed bench for operator_ip_host with a z = a*b + c operator model.
module tb_operator_ip_host;
  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready;
  logic [31:0] cfg_addr, cfg_data;
  logic        job_valid, job_ready;
  logic [31:0] job_a, job_b, job_c;
  logic        res_valid, res_ready;
  logic [63:0] res_z;
  logic [31:0] reg_addr, reg_wr_data;
  logic        reg_wr;
  logic [31:0] a, b, c;
  logic [63:0] z;
  logic        busy;
  logic [2:0]  cfg_level;

  operator_ip_host #(.CFG_DEPTH(4), .OP_LATENCY(2), .WR_GAP(1)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .job_valid(job_valid), .job_ready(job_ready), .job_a(job_a), .job_b(job_b), .job_c(job_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_wr(reg_wr),
    .a(a), .b(b), .c(c), .z(z), .busy(busy), .cfg_level(cfg_level)
  );

  always #5 clk = ~clk;

  assign z = {32'b0, a} * {32'b0, b} + {32'b0, c};

  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, rv_cnt = 0;
  logic [31:0] wr_addr_q[$], wr_data_q[$];
  int          wr_cyc_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reg_wr) begin
      wr_addr_q.push_back(reg_addr);
      wr_data_q.push_back(reg_wr_data);
      wr_cyc_q.push_back(cyc);
    end
    if (res_valid) rv_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic chk_rst(input string tg);
    chk({tg, "_cfg_ready"}, 64'(cfg_ready), 0);
    chk({tg, "_job_ready"}, 64'(job_ready), 0);
    chk({tg, "_reg_wr"},    64'(reg_wr), 0);
    chk({tg, "_res_valid"}, 64'(res_valid), 0);
    chk({tg, "_busy"},      64'(busy), 0);
    chk({tg, "_level"},     64'(cfg_level), 0);
    chk({tg, "_a"},         64'(a), 0);
    chk({tg, "_res_z"},     res_z, 0);
    chk({tg, "_reg_addr"},  64'(reg_addr), 0);
  endtask

  // Call just after a rising edge; returns just after the handshake edge.
  task automatic cfg_push(input logic [31:0] ad, input logic [31:0] d);
    int wt;
    cfg_valid = 1'b1; cfg_addr = ad; cfg_data = d;
    wt = 0;
    @(negedge clk);
    while (!cfg_ready && wt < 50) begin @(negedge clk); wt++; end
    chk("push_ready", 64'(cfg_ready), 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  initial begin
    int n0, rv0, wt;
    rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    job_valid = 1'b0; job_a = '0; job_b = '0; job_c = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_rst("rst0");
    @(posedge clk); #1 rst = 1'b0;

    // Three queued writes, WR_GAP=1 -> strobes two cycles apart
    @(posedge clk); #1;
    cfg_push(32'h10, 32'hA);
    cfg_push(32'h14, 32'hB);
    cfg_push(32'h18, 32'hC);
    repeat (10) @(posedge clk);
    chk("t1_count", 64'(wr_addr_q.size()), 3);
    if (wr_addr_q.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("t1_addr", 64'(wr_addr_q[k]), 64'(32'h10 + 4 * k));
        chk("t1_data", 64'(wr_data_q[k]), 64'(32'hA + k));
      end
      chk("t1_gap01", 64'(wr_cyc_q[1] - wr_cyc_q[0]), 2);
      chk("t1_gap12", 64'(wr_cyc_q[2] - wr_cyc_q[1]), 2);
    end
    @(negedge clk);
    chk("t1_level", 64'(cfg_level), 0);
    chk("t1_addr_hold", 64'(reg_addr), 32'h18);

    // Job 3*5+7, result held while res_ready is low
    @(posedge clk); #1;
    job_valid = 1'b1; job_a = 32'd3; job_b = 32'd5; job_c = 32'd7;
    @(negedge clk); chk("t3_job_ready", 64'(job_ready), 1);
    @(posedge clk); #1 job_valid = 1'b0;
    @(negedge clk); chk("t3_a", 64'(a), 3); chk("t3_rv_t1", 64'(res_valid), 0);
    @(negedge clk); chk("t3_rv_t2", 64'(res_valid), 0);
    @(negedge clk); chk("t3_rv_t3", 64'(res_valid), 1); chk("t3_z", res_z, 22);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_hold_z", res_z, 22);
      chk("t3_hold_rv", 64'(res_valid), 1);
      chk("t3_job_ready_lo", 64'(job_ready), 0);
    end

    // Fill the FIFO while parked in RESP; fifth push waits for the first pop
    @(posedge clk); #1;
    n0 = wr_addr_q.size();
    for (int k = 0; k < 4; k++) cfg_push(32'(32'h100 + 4 * k), 32'(32'h200 + k));
    @(negedge clk);
    chk("t2_level4", 64'(cfg_level), 4);
    chk("t2_full", 64'(cfg_ready), 0);
    cfg_valid = 1'b1; cfg_addr = 32'h110; cfg_data = 32'h204;
    repeat (2) begin @(negedge clk); chk("t2_hold_full", 64'(cfg_ready), 0); end
    chk("t2_no_wr_in_resp", 64'(wr_addr_q.size()), 64'(n0));
    @(posedge clk); #1 res_ready = 1'b1;
    wt = 0;
    @(negedge clk);
    while (!cfg_ready && wt < 50) begin @(negedge clk); wt++; end
    chk("t2_fifth_ready", 64'(cfg_ready), 1);
    chk("t2_after_pop", 64'(wr_addr_q.size()), 64'(n0 + 1));
    @(posedge clk); #1 cfg_valid = 1'b0; res_ready = 1'b0;
    repeat (15) @(posedge clk);
    chk("t2_count", 64'(wr_addr_q.size()), 64'(n0 + 5));
    if (wr_addr_q.size() == n0 + 5)
      for (int k = 0; k < 5; k++) begin
        chk("t2_addr", 64'(wr_addr_q[n0 + k]), 64'(32'h100 + 4 * k));
        chk("t2_data", 64'(wr_data_q[n0 + k]), 64'(32'h200 + k));
      end

    // Cfg push and job in the same IDLE cycle: job first, write after result
    @(posedge clk); #1;
    n0 = wr_addr_q.size();
    cfg_valid = 1'b1; cfg_addr = 32'h40; cfg_data = 32'h44;
    job_valid = 1'b1; job_a = 32'd2; job_b = 32'd10; job_c = 32'd1;
    @(negedge clk);
    chk("t4_job_ready", 64'(job_ready), 1);
    chk("t4_cfg_ready", 64'(cfg_ready), 1);
    @(posedge clk); #1 cfg_valid = 1'b0; job_valid = 1'b0;
    wt = 0;
    @(negedge clk);
    while (!res_valid && wt < 20) begin @(negedge clk); wt++; end
    chk("t4_res_valid", 64'(res_valid), 1);
    chk("t4_z", res_z, 21);
    chk("t4_no_wr", 64'(wr_addr_q.size()), 64'(n0));
    repeat (3) @(negedge clk);
    chk("t4_no_wr_hold", 64'(wr_addr_q.size()), 64'(n0));
    chk("t4_busy", 64'(busy), 1);
    chk("t4_level", 64'(cfg_level), 1);
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    repeat (6) @(posedge clk);
    chk("t4_wr_after", 64'(wr_addr_q.size()), 64'(n0 + 1));
    if (wr_addr_q.size() == n0 + 1) begin
      chk("t4_addr", 64'(wr_addr_q[n0]), 32'h40);
      chk("t4_data", 64'(wr_data_q[n0]), 32'h44);
    end

    // Reset during OP_WAIT
    @(posedge clk); #1;
    job_valid = 1'b1; job_a = 32'd4; job_b = 32'd4; job_c = 32'd4;
    @(negedge clk);
    @(posedge clk); #1 job_valid = 1'b0;
    rv0 = rv_cnt; n0 = wr_addr_q.size();
    chk("t5a_in_op", 64'(a), 4);
    rst = 1'b1; #1;
    chk_rst("t5a");
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    chk("t5a_no_res", 64'(rv_cnt), 64'(rv0));
    chk("t5a_no_wr", 64'(wr_addr_q.size()), 64'(n0));

    // Reset during CFG_GAP with two entries queued
    @(posedge clk); #1;
    n0 = wr_addr_q.size();
    cfg_push(32'h20, 32'h1);
    cfg_push(32'h24, 32'h2);
    cfg_push(32'h28, 32'h3);
    chk("t5b_level2", 64'(cfg_level), 2);
    rst = 1'b1; #1;
    chk_rst("t5b");
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    chk("t5b_one_wr", 64'(wr_addr_q.size()), 64'(n0 + 1));
    chk("t5b_no_res", 64'(rv_cnt), 64'(rv0));
    @(posedge clk); #1;
    cfg_push(32'h30, 32'h5);
    repeat (5) @(posedge clk);
    chk("t5b_new_wr", 64'(wr_addr_q.size()), 64'(n0 + 2));
    if (wr_addr_q.size() == n0 + 2) chk("t5b_new_addr", 64'(wr_addr_q[n0 + 1]), 32'h30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/operator_ip_host.md
Name: operator_ip_host

Overview:
- Host-side sequencer that drives the OPERATOR_IP register-write and operand interface, the initiator end of that port.
- Buffers configuration writes in a small FIFO and issues them as single-cycle `reg_wr` pulses with a configurable gap.
- Presents operand triples on `a`/`b`/`c`, waits a fixed operator latency, captures `z` and returns it over a valid/ready result channel.
- Sits between the control-plane/test driver and the operator wrapper; config writes always complete before the next operand job starts.

Parameters:
- CFG_DEPTH, 4, config FIFO entries; power of 2, range 2..16.
- OP_LATENCY, 2, cycles from operands stable at the operator to `z` valid; range 1..15.
- WR_GAP, 1, idle cycles forced between successive `reg_wr` pulses; range 0..7.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, asynchronous assert, active-high.
- cfg_valid  in  1  config write request valid.
- cfg_ready  out  1  FIFO can accept an entry.
- cfg_addr  in  32  register address.
- cfg_data  in  32  register write data.
- job_valid  in  1  operand job valid.
- job_ready  out  1  job accepted this cycle when high with `job_valid`.
- job_a, job_b, job_c  in  32 each  operands.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_z  out  64  captured operator result.
- reg_addr  out  32  to operator.
- reg_wr_data  out  32  to operator.
- reg_wr  out  1  to operator; one-cycle write strobe.
- a, b, c  out  32 each  operands to operator.
- z  in  64  operator result.
- busy  out  1  state != IDLE or FIFO non-empty.
- cfg_level  out  $clog2(CFG_DEPTH)+1  FIFO occupancy.

Behaviour:

Reset:
- While `rst` is high, all outputs are 0, including `cfg_ready` and `job_ready`.
- FIFO pointers and counters clear and the FSM goes to IDLE.
- Reset mid-operation abandons any in-flight write or job with no `reg_wr` pulse and no result; the FIFO is emptied.

Config FIFO:
- `cfg_ready` = !full && !rst.
- Push on `cfg_valid && cfg_ready`.
- Pop only in CFG_WR. Simultaneous push and pop is legal, and the level is unchanged.
- Full: `cfg_ready` = 0. Pushes are never dropped, because the sender must hold.

FSM states are IDLE, CFG_WR, CFG_GAP, OP_WAIT, RESP.
- IDLE:
  - If the FIFO is non-empty, go to CFG_WR. Config writes have priority over jobs.
  - Otherwise `job_ready` = 1. On `job_valid`, register `job_a/b/c` into `a/b/c` and go to OP_WAIT with the counter set to 0.
  - A job accepted in the same cycle as a cfg push: the job proceeds; the cfg entry waits in the FIFO.
- CFG_WR:
  - For exactly 1 cycle: `reg_wr` = 1, `reg_addr`/`reg_wr_data` = FIFO head, pop.
  - Go to CFG_GAP if WR_GAP > 0, else IDLE.
- CFG_GAP: hold WR_GAP cycles with `reg_wr` = 0, then go to IDLE.
- Write strobe rules:
  - Back-to-back queued writes are spaced WR_GAP+1 cycles apart (pulse to pulse).
  - With WR_GAP = 0 they are consecutive cycles, each passing through IDLE combinationally. The IDLE check therefore happens in the same cycle as the pop decision, not an extra cycle.
  - `reg_addr`/`reg_wr_data` retain their last value after the pulse.
- OP_WAIT:
  - `a/b/c` are held stable.
  - The counter increments each cycle. When it equals OP_LATENCY-1, capture `z` into `res_z`, set `res_valid` = 1 and go to RESP.
  - Net latency: job handshake at cycle T gives `a/b/c` valid from T+1 and `res_valid` rising at T+1+OP_LATENCY.
- RESP:
  - Hold `res_z` and `res_valid` until `res_ready`.
  - On handshake, `res_valid` falls next cycle and the FSM goes to IDLE.
  - `a/b/c` keep their values until the next job is accepted.
  - No new job or config write is issued while in RESP.

Arithmetic:
- Counters are unsigned and sized to their parameter; no wrap is possible because the counters reset on entry to their state.
- `cfg_level` counts 0..CFG_DEPTH.

Decomposition:
- Shared package `operator_ip_pkg`:
  - FSM state enum `op_host_state_e`.
  - Address/data width constants: ADDR_W = 32, DATA_W = 32, RES_W = 64.
  - Struct `op_cfg_wr_t` {addr, data}.
- One sub-module: `op_sync_fifo` (parameterised width/depth, full/empty/level, same-cycle push+pop).
- FSM and datapath live in the top.

Test Plan:
- Reset, then push 3 writes (0x10/0xA, 0x14/0xB, 0x18/0xC) with WR_GAP = 1 -> three `reg_wr` pulses two cycles apart, in order, with matching addr/data; `cfg_level` returns to 0.
- Push CFG_DEPTH+1 writes back-to-back while holding the FSM in RESP -> `cfg_ready` drops at level 4; the 5th is accepted only after the first pop; no loss.
- Job a=3, b=5, c=7 with a model of z=a*b+c after OP_LATENCY=2 -> `res_valid` asserts 3 cycles after the job handshake with `res_z` = 22; `res_ready` held low for 4 cycles -> `res_z` stable, `job_ready` = 0.
- Cfg push and job presented in the same IDLE cycle -> job accepted first, and the `reg_wr` pulse appears only after the result handshake.
- Assert `rst` during OP_WAIT and, separately, during CFG_GAP with 2 entries queued -> all outputs 0 immediately; after release, no `reg_wr` and no `res_valid` until new traffic arrives.
